// File: rtl/dual_issue_queue.sv
// dual_issue_queue
//   Instruction buffer and dual-issue steering stage between fetch and the
//   even/odd execution pipes. Fetched pairs are queued in a circular FIFO;
//   the head pair is steered into the pipe slots it is tagged for. When
//   both instructions of a pair target the same pipe, the pair issues over
//   two cycles (a, then b). Unused slots carry the all-zero nop.
//
//   Build option: define DUAL_ISSUE_EN to let cross-pipe pairs issue in one
//   cycle. Without it every pair takes the two-cycle split path; the pipe
//   tags still pick the slot each instruction lands in.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     fetch_valid/ready     pair handshake from fetch
//     fetch_instr_a/b       instruction pair (a is older)
//     fetch_pipe_a/b        target pipe per instruction (0 even, 1 odd)
//     fetch_pc              PC of a; b sits at fetch_pc+1
//     stall                 downstream hold
//     flush                 discard everything (branch taken)
//     issue_valid           issue registers hold a real instruction
//     instr_even/odd        issue registers per pipe
//     issue_pc              PC of the oldest instruction being issued
module dual_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [0:31]     fetch_instr_a,
  input  logic [0:31]     fetch_instr_b,
  input  logic            fetch_pipe_a,
  input  logic            fetch_pipe_b,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            issue_valid,
  output logic [0:31]     instr_even,
  output logic [0:31]     instr_odd,
  output logic [PC_W-1:0] issue_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  // Entry storage; contents are only meaningful below count, so no reset.
  logic [0:31]     mem_a_q  [DEPTH];
  logic [0:31]     mem_b_q  [DEPTH];
  logic            mem_pa_q [DEPTH];
  logic            mem_pb_q [DEPTH];
  logic [PC_W-1:0] mem_pc_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             a_done_q, a_done_d;
  logic             valid_q, valid_d;
  logic [0:31]      even_q, even_d, odd_q, odd_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic            push, issue, pop, pair_dual;
  logic [0:31]     h_a, h_b, cur_instr;
  logic            h_pa, h_pb, cur_pipe;
  logic [PC_W-1:0] h_pc, cur_pc;

  assign fetch_ready = (count_q != CNT_W'(DEPTH));

  assign h_a  = mem_a_q[head_q];
  assign h_b  = mem_b_q[head_q];
  assign h_pa = mem_pa_q[head_q];
  assign h_pb = mem_pb_q[head_q];
  assign h_pc = mem_pc_q[head_q];

  // On the split path the head slot being issued is a first, then b.
  assign cur_instr = a_done_q ? h_b  : h_a;
  assign cur_pipe  = a_done_q ? h_pb : h_pa;
  assign cur_pc    = a_done_q ? PC_W'(h_pc + 1'b1) : h_pc;

  assign push      = fetch_valid && fetch_ready && !flush;
  assign issue     = !stall && !flush && (count_q != '0);
  assign pair_dual = DUAL && !a_done_q && (h_pa != h_pb);
  // An entry leaves the queue once its last instruction has issued.
  assign pop       = issue && (a_done_q || pair_dual);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    a_done_d = a_done_q;
    valid_d  = valid_q;
    even_d   = even_q;
    odd_d    = odd_q;
    pc_d     = pc_q;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      a_done_d = 1'b0;
      valid_d  = 1'b0;
      even_d   = '0;
      odd_d    = '0;
      pc_d     = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (!stall) begin
        if (count_q == '0) begin
          // Empty: bubble of nops, PC left as last issued.
          valid_d = 1'b0;
          even_d  = '0;
          odd_d   = '0;
        end else if (pair_dual) begin
          valid_d = 1'b1;
          even_d  = h_pa ? h_b : h_a;
          odd_d   = h_pa ? h_a : h_b;
          pc_d    = h_pc;
        end else begin
          valid_d  = 1'b1;
          even_d   = cur_pipe ? '0 : cur_instr;
          odd_d    = cur_pipe ? cur_instr : '0;
          pc_d     = cur_pc;
          a_done_d = !a_done_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[tail_q]  <= fetch_instr_a;
      mem_b_q[tail_q]  <= fetch_instr_b;
      mem_pa_q[tail_q] <= fetch_pipe_a;
      mem_pb_q[tail_q] <= fetch_pipe_b;
      mem_pc_q[tail_q] <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      a_done_q <= 1'b0;
      valid_q  <= 1'b0;
      even_q   <= '0;
      odd_q    <= '0;
      pc_q     <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      a_done_q <= a_done_d;
      valid_q  <= valid_d;
      even_q   <= even_d;
      odd_q    <= odd_d;
      pc_q     <= pc_d;
    end
  end

  assign issue_valid = valid_q;
  assign instr_even  = even_q;
  assign instr_odd   = odd_q;
  assign issue_pc    = pc_q;

endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue. A reference model expands every accepted pair
// into the issue groups it must produce and replays them one per unstalled
// cycle; outputs are compared against it on every falling edge. Directed
// sequences add literal expectations for reset, latency, full/stall, flush,
// pointer wrap and the split path.
module tb_dual_issue_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 8;

`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_valid = 1'b0;
  logic            fetch_ready;
  logic [0:31]     fetch_instr_a = '0;
  logic [0:31]     fetch_instr_b = '0;
  logic            fetch_pipe_a = 1'b0;
  logic            fetch_pipe_b = 1'b0;
  logic [PC_W-1:0] fetch_pc = '0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic            issue_valid;
  logic [0:31]     instr_even;
  logic [0:31]     instr_odd;
  logic [PC_W-1:0] issue_pc;

  always #5 clk = ~clk;

  dual_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr_a(fetch_instr_a), .fetch_instr_b(fetch_instr_b),
    .fetch_pipe_a(fetch_pipe_a), .fetch_pipe_b(fetch_pipe_b), .fetch_pc(fetch_pc),
    .stall(stall), .flush(flush), .issue_valid(issue_valid),
    .instr_even(instr_even), .instr_odd(instr_odd), .issue_pc(issue_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]     e;
    logic [31:0]     o;
    logic [PC_W-1:0] pc;
    bit              last;
  } grp_t;

  grp_t            m_q[$];
  int              m_npairs = 0;
  logic [31:0]     m_even = '0, m_odd = '0;
  logic [PC_W-1:0] m_pc = '0;
  logic            m_valid = 1'b0;

  always @(posedge clk) begin : model
    grp_t g;
    bit   acc;
    acc = fetch_valid && (m_npairs != DEPTH);
    if (reset || flush) begin
      m_q.delete();
      m_npairs = 0;
      m_even = '0; m_odd = '0; m_pc = '0; m_valid = 1'b0;
    end else begin
      if (!stall) begin
        if (m_q.size() == 0) begin
          m_even = '0; m_odd = '0; m_valid = 1'b0;
        end else begin
          g = m_q.pop_front();
          m_even = g.e; m_odd = g.o; m_pc = g.pc; m_valid = 1'b1;
          if (g.last) m_npairs--;
        end
      end
      if (acc) begin
        m_npairs++;
        if (DUAL && fetch_pipe_a != fetch_pipe_b) begin
          g.e    = fetch_pipe_a ? fetch_instr_b : fetch_instr_a;
          g.o    = fetch_pipe_a ? fetch_instr_a : fetch_instr_b;
          g.pc   = fetch_pc;
          g.last = 1'b1;
          m_q.push_back(g);
        end else begin
          g.e    = fetch_pipe_a ? 32'h0 : fetch_instr_a;
          g.o    = fetch_pipe_a ? fetch_instr_a : 32'h0;
          g.pc   = fetch_pc;
          g.last = 1'b0;
          m_q.push_back(g);
          g.e    = fetch_pipe_b ? 32'h0 : fetch_instr_b;
          g.o    = fetch_pipe_b ? fetch_instr_b : 32'h0;
          g.pc   = PC_W'(fetch_pc + 1);
          g.last = 1'b1;
          m_q.push_back(g);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_ready", 32'(fetch_ready), 32'(m_npairs != DEPTH));
      check("mdl_valid", 32'(issue_valid), 32'(m_valid));
      check("mdl_even",  instr_even, m_even);
      check("mdl_odd",   instr_odd,  m_odd);
      check("mdl_pc",    32'(issue_pc), 32'(m_pc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setpair(input logic [31:0] a, input logic [31:0] b,
                         input logic pa, input logic pb, input logic [PC_W-1:0] pc);
    fetch_instr_a = a;
    fetch_instr_b = b;
    fetch_pipe_a  = pa;
    fetch_pipe_b  = pb;
    fetch_pc      = pc;
  endtask

  initial begin
    int  vcnt;
    int  i;
    bit  acc;
    bit  got;

    // Reset state
    cyc(); cyc();
    check("rst_valid", 32'(issue_valid), 32'h0);
    check("rst_even",  instr_even, 32'h0);
    check("rst_odd",   instr_odd, 32'h0);
    check("rst_pc",    32'(issue_pc), 32'h0);
    check("rst_ready", 32'(fetch_ready), 32'h1);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Cross-pipe pair
    setpair(32'h1C000083, 32'h34000103, 1'b0, 1'b1, 8'h10);
    fetch_valid = 1'b1;
    cyc();
    fetch_valid = 1'b0;
    cyc();
    check("x_valid", 32'(issue_valid), 32'h1);
    check("x_even",  instr_even, 32'h1C000083);
    check("x_pc",    32'(issue_pc), 32'h10);
    if (DUAL) begin
      check("x_odd", instr_odd, 32'h34000103);
    end else begin
      check("x_odd_split", instr_odd, 32'h0);
      cyc();
      check("x2_even", instr_even, 32'h0);
      check("x2_odd",  instr_odd, 32'h34000103);
      check("x2_pc",   32'(issue_pc), 32'h11);
    end
    cyc(); cyc();

    // Same-pipe pair, both even
    setpair(32'h11111111, 32'h22222222, 1'b0, 1'b0, 8'h20);
    fetch_valid = 1'b1;
    cyc();
    fetch_valid = 1'b0;
    cyc();
    check("s_even", instr_even, 32'h11111111);
    check("s_odd",  instr_odd, 32'h0);
    check("s_pc",   32'(issue_pc), 32'h20);
    cyc();
    check("s2_even", instr_even, 32'h22222222);
    check("s2_odd",  instr_odd, 32'h0);
    check("s2_pc",   32'(issue_pc), 32'h21);
    cyc(); cyc();

    // Fill under stall; fifth push held off
    stall = 1'b1;
    fetch_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      setpair(32'hA0000000 + 32'(k), 32'hB0000000 + 32'(k), 1'b0, 1'b1, PC_W'(8'h40 + 2*k));
      cyc();
      if (k == 3) check("full_ready", 32'(fetch_ready), 32'h0);
    end
    check("full_ready_held", 32'(fetch_ready), 32'h0);
    stall = 1'b0;
    cyc();
    check("drain_first_pc",   32'(issue_pc), 32'h40);
    check("drain_first_even", instr_even, 32'hA0000000);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      acc = fetch_ready;
      cyc();
      if (acc) got = 1'b1;
    end
    check("fifth_accepted", 32'(got), 32'h1);
    fetch_valid = 1'b0;
    repeat (14) cyc();
    check("drain_valid", 32'(issue_valid), 32'h0);
    check("drain_last_pc", 32'(issue_pc), DUAL ? 32'h48 : 32'h49);

    // Flush with three queued and a push offered
    stall = 1'b1;
    fetch_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      setpair(32'hC0000000 + 32'(k), 32'hD0000000 + 32'(k), 1'b1, 1'b0, PC_W'(8'h60 + 2*k));
      cyc();
    end
    setpair(32'hEEEEEEEE, 32'hFFFFFFFF, 1'b0, 1'b1, 8'h70);
    flush = 1'b1;
    cyc();
    check("fl_valid", 32'(issue_valid), 32'h0);
    check("fl_even",  instr_even, 32'h0);
    check("fl_odd",   instr_odd, 32'h0);
    check("fl_pc",    32'(issue_pc), 32'h0);
    check("fl_ready", 32'(fetch_ready), 32'h1);
    flush = 1'b0;
    stall = 1'b0;
    fetch_valid = 1'b0;
    repeat (5) cyc();
    check("fl_after_valid", 32'(issue_valid), 32'h0);

    // Pointer wrap: 2*DEPTH+1 cross-pipe pairs, contiguous PCs
    vcnt = 0;
    i = 0;
    for (int k = 0; k < 100 && i < 2*DEPTH+1; k++) begin
      setpair(32'h50000000 + 32'(i), 32'h60000000 + 32'(i), 1'b1, 1'b0, PC_W'(8'h80 + 2*i));
      fetch_valid = 1'b1;
      acc = fetch_ready;
      cyc();
      if (issue_valid) vcnt++;
      if (acc) i++;
    end
    check("wrap_pushed", 32'(i), 32'(2*DEPTH+1));
    fetch_valid = 1'b0;
    repeat (24) begin
      cyc();
      if (issue_valid) vcnt++;
    end
    check("wrap_groups", 32'(vcnt), DUAL ? 32'(2*DEPTH+1) : 32'(2*(2*DEPTH+1)));
    check("wrap_last_pc", 32'(issue_pc), DUAL ? 32'h90 : 32'h91);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
